// File: rtl/i2c_reg_access.sv
`default_nettype none
// ============================================================================
// i2c_reg_access : one-request I2C register write / read (repeated START)
//                  sequencer that drives an I2C byte engine.
// Revision       : 1.0
// ============================================================================
module i2c_reg_access #(
    parameter int          ADDR_BYTES = 1,
    parameter logic [23:0] TIMEOUT    = 24'd2000000
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        rw,
    input  logic [6:0]  dev,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rdata,
    output logic [3:0]  i2c_cmd,
    output logic [7:0]  i2c_din,
    input  logic [7:0]  i2c_dout,
    input  logic        i2c_ack,
    input  logic        i2c_noack
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WACK  = 3'd2,
        S_WDONE = 3'd3,
        S_NEXT  = 3'd4
    } state_t;

    localparam logic [2:0]  ABYTES           = 3'(ADDR_BYTES);
    localparam logic [3:0]  CMD_START_WR     = 4'b0110;
    localparam logic [3:0]  CMD_WR           = 4'b0100;
    localparam logic [3:0]  CMD_WR_STOP      = 4'b0101;
    localparam logic [3:0]  CMD_RD_NACK_STOP = 4'b1101;
    localparam logic [23:0] TIMER_MAX        = 24'hFFFFFF;

    state_t      state, state_nx;
    logic [2:0]  idx, idx_nx;
    logic [23:0] timer, timer_nx;
    logic [3:0]  cmd_q, cmd_nx;
    logic [7:0]  din_q, din_nx;
    logic        done_q, done_nx;
    logic        err_q, err_nx;
    logic [7:0]  rdata_q, rdata_nx;
    logic        rw_q;
    logic [6:0]  dev_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        load;
    logic [2:0]  last_idx;
    logic [3:0]  byte_cmd;
    logic [7:0]  byte_dat;
    logic        waiting;
    logic        timed_out;

    // Byte table: index -> engine command and payload for the current request
    always_comb begin
        byte_cmd = CMD_WR;
        byte_dat = addr_q[7:0];
        if (idx == 3'd0) begin
            byte_cmd = CMD_START_WR;
            byte_dat = {dev_q, 1'b0};
        end else if (idx <= ABYTES) begin
            byte_cmd = CMD_WR;
            byte_dat = (ADDR_BYTES == 2 && idx == 3'd1) ? addr_q[15:8] : addr_q[7:0];
        end else if (idx == ABYTES + 3'd1) begin
            byte_cmd = rw_q ? CMD_START_WR : CMD_WR_STOP;
            byte_dat = rw_q ? {dev_q, 1'b1} : wdata_q;
        end else begin
            byte_cmd = CMD_RD_NACK_STOP;
            byte_dat = 8'h00;
        end
    end

    assign last_idx  = rw_q ? (ABYTES + 3'd2) : (ABYTES + 3'd1);
    assign waiting   = (state == S_WACK) || (state == S_WDONE);
    assign timed_out = waiting && (timer >= TIMEOUT - 24'd1);

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cmd_nx   = cmd_q;
        din_nx   = din_q;
        done_nx  = 1'b0;
        err_nx   = err_q;
        rdata_nx = rdata_q;
        load     = 1'b0;
        timer_nx = timer;

        case (state)
            S_IDLE: begin
                if (req) begin
                    load     = 1'b1;
                    err_nx   = 1'b0;
                    idx_nx   = 3'd0;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cmd_nx   = byte_cmd;
                din_nx   = byte_dat;
                state_nx = S_WACK;
            end
            S_WACK: begin
                if (i2c_ack) begin
                    cmd_nx   = 4'h0;
                    state_nx = S_WDONE;
                end
            end
            S_WDONE: begin
                if (!i2c_ack) begin
                    state_nx = S_NEXT;
                end
            end
            S_NEXT: begin
                // A NACKed write byte ends the transfer; the engine has already sent STOP
                if (byte_cmd[3:2] == 2'b01 && i2c_noack) begin
                    done_nx  = 1'b1;
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end else if (idx == last_idx) begin
                    if (rw_q) begin
                        rdata_nx = i2c_dout;
                    end
                    done_nx  = 1'b1;
                    err_nx   = 1'b0;
                    state_nx = S_IDLE;
                end else begin
                    idx_nx   = idx + 3'd1;
                    state_nx = S_ISSUE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (timed_out) begin
            cmd_nx   = 4'h0;
            done_nx  = 1'b1;
            err_nx   = 1'b1;
            state_nx = S_IDLE;
        end

        if (state_nx != state) begin
            timer_nx = 24'd0;
        end else if (waiting && timer != TIMER_MAX) begin
            timer_nx = timer + 24'd1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= 3'd0;
            timer   <= 24'd0;
            cmd_q   <= 4'h0;
            din_q   <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
            rw_q    <= 1'b0;
            dev_q   <= 7'h00;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            timer   <= timer_nx;
            cmd_q   <= cmd_nx;
            din_q   <= din_nx;
            done_q  <= done_nx;
            err_q   <= err_nx;
            rdata_q <= rdata_nx;
            if (load) begin
                rw_q    <= rw;
                dev_q   <= dev;
                addr_q  <= reg_addr;
                wdata_q <= wdata;
            end
        end
    end

    assign busy    = (state != S_IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign i2c_cmd = cmd_q;
    assign i2c_din = din_q;

endmodule
`default_nettype wire

// File: doc/i2c_reg_access.md
Name: i2c_reg_access

Overview:
Register-level I2C transaction sequencer. It sits directly upstream of the I2C byte engine, drives its cmd/din, and consumes its dout/ack/noack. A single request runs a complete single-byte register write or register read (with repeated START) on a 7-bit slave. Clients such as the video DAC/codec setup logic and the CPU port get a simple req/done/err interface.

Parameters:
ADDR_BYTES, 1, register address width in bytes (1 or 2; MSB byte sent first)
TIMEOUT, 24'd2000000, max refclk cycles to wait on any byte-engine handshake edge before err

Ports:
refclk  in  1  system clock, same clock as the byte engine
rst_n  in  1  asynchronous active-low reset
req  in  1  start transaction; sampled only in IDLE
rw  in  1  0=register write, 1=register read
dev  in  7  slave address, latched on accept
reg_addr  in  16  register address, latched on accept; upper byte ignored when ADDR_BYTES=1
wdata  in  8  write data, latched on accept
busy  out  1  high from accept until done pulse
done  out  1  one-cycle pulse at transaction end (success or error)
err  out  1  valid with done: 1=slave NACK or timeout
rdata  out  8  read result, updated at successful read completion, held otherwise
i2c_cmd  out  4  to byte engine: 01xx=wr, 10xx=rd+ack, 11xx=rd+nack, xx1x=start, xxx1=stop, 0000=idle
i2c_din  out  8  byte to transmit, stable while i2c_cmd nonzero
i2c_dout  in  8  received byte from engine
i2c_ack  in  1  engine handshake
i2c_noack  in  1  engine: last written byte NACKed

Behaviour:
- Reset (async, rst_n=0): state IDLE; i2c_cmd=0, i2c_din=0, busy=0, done=0, err=0, rdata=0, index/timer cleared. Reset mid-transaction drops i2c_cmd to 0 immediately. No STOP is generated.
- Byte handshake, per byte:
  - ISSUE: drive i2c_cmd/i2c_din; go to WACK.
  - WACK: hold cmd until i2c_ack=1, then drive i2c_cmd=0 and go to WDONE.
  - WDONE: wait for i2c_ack=0. The byte is now complete and i2c_dout/i2c_noack are valid; go to NEXT.
  - i2c_din changes only in ISSUE.
- Byte sequences (index 0..n-1, n = ADDR_BYTES+2 for write, ADDR_BYTES+3 for read):
  - write: {dev,0} cmd 0110; addr byte(s) 0100; wdata 0101.
  - read: {dev,0} 0110; addr byte(s) 0100; {dev,1} 0110 (repeated START); read 1101 (NACK+STOP).
- NEXT:
  - If the completed byte was a write byte and i2c_noack=1: abort. The engine has already issued STOP. Pulse done with err=1; rdata unchanged.
  - Else, if the last byte: on read, rdata<=i2c_dout; pulse done with err=0.
  - Else increment index and go to ISSUE.
- done and err are asserted in the same cycle. busy falls in that cycle. IDLE is re-entered the next cycle. err stays valid until the next accept, where it is cleared.
- Timer: cleared on every state change. Counts while in WACK or WDONE. Reaching TIMEOUT forces i2c_cmd=0 and pulses done with err=1 (covers clock-stretch hang or missing engine). Timer width is 24 bits and saturates; no wrap.
- req held high after done starts a new transaction from IDLE one cycle later. req while busy is ignored.
- Latency: accept-to-first-cmd = 1 cycle. Minimum per-byte overhead beyond engine time = 3 cycles.
- i2c_ack already high on entering WACK (stale): treated as an acknowledgement. The engine guarantees ack=0 before ISSUE by construction of WDONE.

Test Plan:
- Write, ADDR_BYTES=1, dev=7'h1A, reg=8'h05, wdata=8'hC3, engine model ACKs all: i2c_din sequence 34,05,C3 with cmds 6,4,5 → done, err=0, busy high throughout.
- Read, ADDR_BYTES=2, dev=7'h50, reg=16'h0123, model returns 8'h5A: din 0xA0,01,23,0xA1 and cmds 6,4,4,6,then 0xD (din don't-care) → rdata=8'h5A, err=0, exactly 5 bytes issued.
- NACK on address byte (noack=1 after byte 0) → no further cmd issued, done+err=1, rdata keeps previous value 8'h5A.
- Engine never raises i2c_ack, TIMEOUT=100 → i2c_cmd returns 0 and done+err=1 at 100 cycles after ISSUE (±1).
- rst_n low during WDONE of byte 2 → i2c_cmd=0, busy=0 asynchronously; a following req after reset release runs a clean full sequence.
- Back-to-back: req held high for two writes → second transaction's first cmd appears 2 cycles after the first done; req pulsed while busy → ignored.
